// File: rtl/dmem_responder.sv
// Wait-state doubleword memory responder: accepts one load/store at a time and
// returns its result over a valid/ready response channel after LATENCY cycles.
module dmem_responder #(
   parameter int DEPTH_LOG2 = 5,
   parameter int LATENCY    = 3
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                 state;
   logic [3:0]             count;
   logic                   idle_q;
   logic [63:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  index;
   logic                   req_err;
   logic                   accept;

   assign index   = req_addr[DEPTH_LOG2+2:3];
   // Any set bit above the index field puts the doubleword index past the store.
   assign req_err = (req_addr[2:0] != 3'b000) || (req_addr[63:DEPTH_LOG2+3] != '0);

   // idle_q comes out of reset as 1, so resetl gates it to keep req_ready low in reset.
   assign req_ready = idle_q && resetl;
   assign accept    = req_valid && req_ready;

   // Storage has no reset: contents survive resetl and start uninitialised.
   always_ff @(posedge CLK) begin
      if (accept && req_write && !req_err) begin
         mem[index] <= req_wdata;
      end
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state     <= IDLE;
         count     <= 4'd0;
         idle_q    <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 64'd0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rsp_err   <= req_err;
                  rsp_rdata <= (req_err || req_write) ? 64'd0 : mem[index];
                  count     <= CNT_LOAD;
                  state     <= BUSY;
                  idle_q    <= 1'b0;
               end
            end
            BUSY: begin
               if (count == 4'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  count <= count - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  idle_q    <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               idle_q    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic
// compared against an array-based memory model.
module tb_dmem_responder;

   logic        CLK = 1'b0;
   logic        resetl = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
   logic [63:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [63:0] rsp_rdata;

   logic        req_valid_b = 1'b0, req_write_b = 1'b0, rsp_ready_b = 1'b1;
   logic [63:0] req_addr_b = '0, req_wdata_b = '0;
   logic        req_ready_b, rsp_valid_b, rsp_err_b;
   logic [63:0] rsp_rdata_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] mdl [32];
   bit          known [32];

   always #5 CLK = ~CLK;

   dmem_responder #(.DEPTH_LOG2(5), .LATENCY(3)) dut (
      .CLK(CLK), .resetl(resetl),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DEPTH_LOG2(5), .LATENCY(1)) dut_b (
      .CLK(CLK), .resetl(resetl),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
      .req_addr(req_addr_b), .req_wdata(req_wdata_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
      .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
   );

   // Reference rule: error if not 8-byte aligned or doubleword index >= 32.
   function automatic bit ref_err(input logic [63:0] a);
      return ((a % 64'd8) != 64'd0) || ((a / 64'd8) >= 64'd32);
   endfunction

   // Applies a transaction to the model; returns expected response and whether the data is defined.
   function automatic void model_apply(input logic w, input logic [63:0] a, input logic [63:0] d,
                                       output logic [63:0] exp_rd, output logic exp_e,
                                       output bit exp_known);
      int i;
      exp_e     = ref_err(a);
      exp_rd    = 64'd0;
      exp_known = 1'b1;
      if (!exp_e) begin
         i = int'(a / 64'd8);
         if (w) begin
            mdl[i]   = d;
            known[i] = 1'b1;
         end else begin
            exp_rd    = mdl[i];
            exp_known = known[i];
         end
      end
   endfunction

   // Issues one request on the LATENCY=3 port and reports the response and accept-to-valid edges.
   task automatic drive(input logic w, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] rd, output logic e, output int lat);
      int n;
      rd = '0; e = 1'b0; lat = 0;
      @(negedge CLK);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      @(posedge CLK);
      #1 req_valid = 1'b0;
      do begin
         @(posedge CLK);
         #1;
         lat++;
      end while (!rsp_valid && lat < 50);
      rd = rsp_rdata;
      e  = rsp_err;
      $display("txn w=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d", w, a, d, rd, e, lat);
      if (rsp_ready && rsp_valid) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLK);
      n_checks += 4;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
      if (rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
      resetl = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready: got %b expected 1", req_ready); end
   endtask

   task automatic test_round_trip();
      logic [63:0] rd, exp_rd; logic e, exp_e; bit k; int lat;
      drive(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, rd, e, lat);
      model_apply(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, exp_rd, exp_e, k);
      n_checks += 3;
      if (lat !== 3) begin n_fail++; $display("FAIL rt_store_latency: got %0d expected 3", lat); end
      if (e !== 1'b0) begin n_fail++; $display("FAIL rt_store_err: got %b expected 0", e); end
      if (rd !== 64'd0) begin n_fail++; $display("FAIL rt_store_rdata: got %h expected 0", rd); end
      drive(1'b1, 64'h18, 64'h0BAD_F00D_1111_2222, rd, e, lat);
      model_apply(1'b1, 64'h18, 64'h0BAD_F00D_1111_2222, exp_rd, exp_e, k);
      drive(1'b0, 64'h10, 64'h0, rd, e, lat);
      model_apply(1'b0, 64'h10, 64'h0, exp_rd, exp_e, k);
      n_checks += 3;
      if (lat !== 3) begin n_fail++; $display("FAIL rt_load_latency: got %0d expected 3", lat); end
      if (e !== 1'b0) begin n_fail++; $display("FAIL rt_load_err: got %b expected 0", e); end
      if (rd !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL rt_load_rdata: got %h expected deadbeefcafef00d", rd); end
   endtask

   task automatic test_misaligned();
      logic [63:0] rd, exp_rd; logic e, exp_e; bit k; int lat;
      drive(1'b1, 64'h08, 64'h0123_4567_89AB_CDEF, rd, e, lat);
      model_apply(1'b1, 64'h08, 64'h0123_4567_89AB_CDEF, exp_rd, exp_e, k);
      drive(1'b0, 64'h13, 64'h0, rd, e, lat);
      n_checks += 2;
      if (e !== 1'b1) begin n_fail++; $display("FAIL mis_load_err: got %b expected 1", e); end
      if (rd !== 64'd0) begin n_fail++; $display("FAIL mis_load_rdata: got %h expected 0", rd); end
      drive(1'b1, 64'h0B, 64'hFFFF, rd, e, lat);
      n_checks += 2;
      if (e !== 1'b1) begin n_fail++; $display("FAIL mis_store_err: got %b expected 1", e); end
      if (rd !== 64'd0) begin n_fail++; $display("FAIL mis_store_rdata: got %h expected 0", rd); end
      drive(1'b0, 64'h08, 64'h0, rd, e, lat);
      n_checks += 2;
      if (e !== 1'b0) begin n_fail++; $display("FAIL mis_reload_err: got %b expected 0", e); end
      if (rd !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL mis_reload_rdata: got %h expected 0123456789abcdef", rd); end
   endtask

   task automatic test_out_of_range();
      logic [63:0] rd, exp_rd; logic e, exp_e; bit k; int lat;
      drive(1'b0, 64'h100, 64'h0, rd, e, lat);
      n_checks += 2;
      if (e !== 1'b1) begin n_fail++; $display("FAIL oor_load_err: got %b expected 1", e); end
      if (rd !== 64'd0) begin n_fail++; $display("FAIL oor_load_rdata: got %h expected 0", rd); end
      drive(1'b0, 64'h8000_0000_0000_0010, 64'h0, rd, e, lat);
      n_checks++;
      if (e !== 1'b1) begin n_fail++; $display("FAIL oor_high_err: got %b expected 1", e); end
      drive(1'b1, 64'hF8, 64'h5555, rd, e, lat);
      model_apply(1'b1, 64'hF8, 64'h5555, exp_rd, exp_e, k);
      drive(1'b0, 64'hF8, 64'h0, rd, e, lat);
      n_checks += 2;
      if (e !== 1'b0) begin n_fail++; $display("FAIL top_load_err: got %b expected 0", e); end
      if (rd !== 64'h5555) begin n_fail++; $display("FAIL top_load_rdata: got %h expected 5555", rd); end
   endtask

   task automatic test_backpressure();
      logic [63:0] rd0, rd, exp_rd; logic e0, e, exp_e; bit k; int n, lat;
      rsp_ready = 1'b0;
      @(negedge CLK);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_wdata = '0;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge CLK); n++; end
      @(posedge CLK);
      #1 req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge CLK); #1; n++; end
      rd0 = rsp_rdata; e0 = rsp_err;
      n_checks += 2;
      if (rd0 !== mdl[2]) begin n_fail++; $display("FAIL bp_rdata: got %h expected %h", rd0, mdl[2]); end
      if (e0 !== 1'b0) begin n_fail++; $display("FAIL bp_err: got %b expected 0", e0); end
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h18; req_wdata = '1;
         @(posedge CLK);
         #1;
         n_checks += 4;
         if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, rsp_valid); end
         if (rsp_rdata !== rd0) begin n_fail++; $display("FAIL bp_hold_rdata[%0d]: got %h expected %h", i, rsp_rdata, rd0); end
         if (rsp_err !== e0) begin n_fail++; $display("FAIL bp_hold_err[%0d]: got %b expected %b", i, rsp_err, e0); end
         if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", i, req_ready); end
      end
      @(negedge CLK);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      n_checks += 2;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", rsp_valid); end
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
      drive(1'b0, 64'h18, 64'h0, rd, e, lat);
      model_apply(1'b0, 64'h18, 64'h0, exp_rd, exp_e, k);
      n_checks++;
      if (rd !== exp_rd) begin n_fail++; $display("FAIL bp_ignored_store: got %h expected %h", rd, exp_rd); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] rd, exp_rd; logic e, exp_e; bit k; int n, seen, lat;
      @(negedge CLK);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'h1234;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge CLK); n++; end
      @(posedge CLK);
      #1 req_valid = 1'b0;
      model_apply(1'b1, 64'h20, 64'h1234, exp_rd, exp_e, k);
      @(posedge CLK);
      #1 resetl = 1'b0;
      #1;
      n_checks += 3;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", rsp_valid); end
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 0", req_ready); end
      if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b expected 0", rsp_err); end
      repeat (2) @(negedge CLK);
      resetl = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK);
         #1;
         if (rsp_valid) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_rsp: got %0d responses expected 0", seen); end
      drive(1'b0, 64'h20, 64'h0, rd, e, lat);
      n_checks++;
      if (rd !== 64'h1234) begin n_fail++; $display("FAIL rstmid_kept: got %h expected 1234", rd); end
   endtask

   task automatic test_random();
      logic [63:0] a, d, rd, exp_rd; logic w, e, exp_e; bit k; int lat, sel, idx;
      for (int t = 0; t < 40; t++) begin
         sel = $urandom_range(0, 9);
         idx = $urandom_range(0, 31);
         if (sel <= 6)       a = 64'(idx) * 64'd8;
         else if (sel == 7)  a = 64'(idx) * 64'd8 + 64'($urandom_range(1, 7));
         else if (sel == 8)  a = 64'($urandom_range(32, 4000)) * 64'd8;
         else                a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
         w = 1'($urandom_range(0, 1));
         d = {$urandom, $urandom};
         drive(w, a, d, rd, e, lat);
         model_apply(w, a, d, exp_rd, exp_e, k);
         n_checks += 2;
         if (e !== exp_e) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", t, e, exp_e); end
         if (lat !== 3) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected 3", t, lat); end
         if (k) begin
            n_checks++;
            if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", t, rd, exp_rd); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc[$];
      int vhi[$];
      bit pre;
      @(negedge CLK);
      req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 64'h0;
      for (int c = 0; c < 12; c++) begin
         pre = req_valid_b && req_ready_b;
         @(posedge CLK);
         #1;
         if (pre) begin
            acc.push_back(c);
            if (acc.size() == 1) req_addr_b = 64'h8;
            else req_valid_b = 1'b0;
         end
         if (rsp_valid_b) vhi.push_back(c);
         @(negedge CLK);
      end
      req_valid_b = 1'b0;
      $display("txn b2b accepts=%p valid_edges=%p", acc, vhi);
      n_checks += 2;
      if (acc.size() !== 2) begin
         n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", acc.size());
      end else if (acc[1] - acc[0] !== 3) begin
         n_fail++; $display("FAIL b2b_accept_gap: got %0d expected 3", acc[1] - acc[0]);
      end
      if (acc.size() < 1 || vhi.size() !== 2) begin
         n_fail++; $display("FAIL b2b_valid_count: got %0d expected 2", vhi.size());
      end else if (vhi[0] !== acc[0] + 1 || vhi[1] !== acc[0] + 4) begin
         n_fail++; $display("FAIL b2b_valid_edges: got %0d,%0d expected %0d,%0d", vhi[0], vhi[1], acc[0] + 1, acc[0] + 4);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mdl[i] = '0;
         known[i] = 1'b0;
      end
      test_reset();
      test_round_trip();
      test_misaligned();
      test_out_of_range();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
